// File: rtl/uart_tx_scheduler.sv
// Round-robin UART transmit scheduler: arbitrates NUM_REQ byte sources onto one 8N1 line (8E1 when UART_TX_SCHED_PARITY_EN is defined).
// Latency: req_ready is raised combinationally in IDLE; the start bit is on tx the next clk; a frame lasts 10*OVERSAMPLE (11*OVERSAMPLE) baud_ticks.
// Backpressure: requesters hold req_valid/req_data until their one-clk req_ready; nothing is accepted while busy or in the frame_done cycle.
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       baud_tick,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [GW-1:0] PTR_RST   = GW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_SCHED_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    state_t          state_q, state_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
`ifdef UART_TX_SCHED_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic [GW-1:0]   pick;
    logic            pick_vld;
    logic [7:0]      pick_byte;
    logic            accept;
    logic            bit_end;

    // Round-robin search: walk from the farthest candidate back to the nearest,
    // so the valid requester closest after last_grant is the one that sticks.
    always_comb begin
        int idx;
        idx       = 0;
        pick      = last_grant_q;
        pick_vld  = 1'b0;
        pick_byte = 8'h00;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                pick      = GW'(idx);
                pick_vld  = 1'b1;
                pick_byte = req_data[idx*8 +: 8];
            end
        end
    end

    // Acceptance only from IDLE, and never in the frame_done cycle, so
    // consecutive frames cannot overlap their handshake pulses.
    assign accept  = (state_q == IDLE) && !frame_done_q && pick_vld;
    assign bit_end = baud_tick && (tick_cnt_q == TICK_LAST);

    // One-hot acceptance pulse for the winning requester.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (pick == GW'(i));
        end
    end

    // Frame sequencer next-state: each bit lasts OVERSAMPLE baud_ticks, the
    // following bit level is driven on the clk after the last tick of a bit.
    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
`ifdef UART_TX_SCHED_PARITY_EN
        parity_d     = parity_q;
`endif

        if (state_q != IDLE && baud_tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                // Ticks seen while idle are dropped so each frame is phase-aligned
                // to its acceptance; the start bit may run up to one tick short.
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_d       = 1'b1;
                if (accept) begin
                    state_d      = START;
                    tx_d         = 1'b0;
                    busy_d       = 1'b1;
                    grant_id_d   = pick;
                    last_grant_d = pick;
                    shift_d      = pick_byte;
`ifdef UART_TX_SCHED_PARITY_EN
                    parity_d     = ^pick_byte;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_SCHED_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d      = IDLE;
                    tx_d         = 1'b1;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            grant_id_q   <= '0;
            last_grant_q <= PTR_RST;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
`ifdef UART_TX_SCHED_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
`ifdef UART_TX_SCHED_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;
    assign frame_done = frame_done_q;

endmodule
